// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory responder.
package mem_pkg;

  // Bytes per memory word; the low address bits select a byte within a word.
  localparam int WORD_BYTES = 4;
  // Largest wait-state count the 4-bit latency counter can hold.
  localparam int MAX_WAIT   = 15;
  // Width of the wait-state counter.
  localparam int CNT_W      = 4;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  // Kind of access latched at acceptance.
  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } mem_op_t;

  // Turns the wait-state parameter into a counter load value, saturated to the legal range.
  function automatic logic [CNT_W-1:0] wait_load(input int cycles);
    logic [CNT_W-1:0] v;
    if (cycles > MAX_WAIT) begin
      v = 4'(MAX_WAIT);
    end else if (cycles < 0) begin
      v = 4'd0;
    end else begin
      v = 4'(cycles);
    end
    return v;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, synchronous read.
// The contents and the read register are deliberately not reset.
module mem_array #(
  parameter int    ADDR_W    = 8,
  parameter int    DATA_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port: store the word when the responder commits a write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read port: capture the word only on a committed read so the value holds afterwards.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the multicycle processor: accepts a read/write strobe,
// waits WAIT_CYCLES edges, performs the access and pulses mem_ready for one cycle.
// Misaligned, out-of-range or read+write requests complete with mem_err and no side effect.
module mem_responder
  import mem_pkg::*;
#(
  parameter int    ADDR_W      = 8,
  parameter int    DATA_W      = 32,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              busy
);

  localparam int               OFS_W     = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] WAIT_LD   = wait_load(WAIT_CYCLES);
  localparam bit               ZERO_WAIT = (WAIT_LD == 4'd0);

  // Flags an address that is not word aligned or falls outside the array.
  function automatic logic addr_err(input logic [31:0] a);
    logic bad_align;
    logic bad_range;
    bad_align = (a[OFS_W-1:0] != '0);
    bad_range = (a[31:ADDR_W+OFS_W] != '0);
    return bad_align | bad_range;
  endfunction

  mem_state_t        r_state;
  mem_state_t        w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_wdata;
  mem_op_t           r_op;
  logic              r_err;
  logic              r_rd_seen;

  logic              w_strobe;
  logic              w_accept;
  logic              w_req_err;
  mem_op_t           w_req_op;
  logic              w_access;
  logic [ADDR_W-1:0] w_acc_idx;
  logic [DATA_W-1:0] w_acc_wdata;
  mem_op_t           w_acc_op;
  logic              w_acc_err;
  logic              w_do_write;
  logic              w_do_read;
  logic [DATA_W-1:0] w_arr_rdata;

  assign w_strobe  = mem_read | mem_write;
  assign w_accept  = (r_state == IDLE) & w_strobe;
  assign w_req_err = addr_err(addr) | (mem_read & mem_write);
  assign w_req_op  = mem_write ? WR : RD;

  // Decide when the access commits and which request fields it uses: with no wait
  // states the live request is used at acceptance, otherwise the latched copy.
  always_comb begin
    w_access    = 1'b0;
    w_acc_idx   = r_idx;
    w_acc_wdata = r_wdata;
    w_acc_op    = r_op;
    w_acc_err   = r_err;
    case (r_state)
      IDLE: begin
        if (ZERO_WAIT && w_accept) begin
          w_access    = 1'b1;
          w_acc_idx   = addr[ADDR_W+OFS_W-1:OFS_W];
          w_acc_wdata = wdata;
          w_acc_op    = w_req_op;
          w_acc_err   = w_req_err;
        end else begin
          w_access    = 1'b0;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_access = 1'b1;
        end else begin
          w_access = 1'b0;
        end
      end
      DONE:    w_access = 1'b0;
      default: w_access = 1'b0;
    endcase
  end

  assign w_do_write = w_access & ~w_acc_err & (w_acc_op == WR);
  assign w_do_read  = w_access & ~w_acc_err & (w_acc_op == RD);

  // Next-state logic for the IDLE -> (WAIT) -> DONE -> IDLE sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_strobe) begin
          if (ZERO_WAIT) begin
            w_next_state = DONE;
          end else begin
            w_next_state = WAIT;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next_state = DONE;
        end else begin
          w_next_state = WAIT;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State, wait counter and request latches; the latches only load at acceptance so
  // later strobe/address/data changes are ignored until the block is back in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_op      <= RD;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt   <= WAIT_LD;
            r_idx   <= addr[ADDR_W+OFS_W-1:OFS_W];
            r_wdata <= wdata;
            r_op    <= w_req_op;
            r_err   <= w_req_err;
          end
        end
        WAIT:    r_cnt <= r_cnt - 4'd1;
        DONE:    r_cnt <= r_cnt;
        default: r_cnt <= 4'd0;
      endcase
    end
  end

  // Tracks whether any read has landed since reset; until then rdata reads as zero
  // because the array's read register itself has no reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_seen <= 1'b0;
    end else if (w_do_read) begin
      r_rd_seen <= 1'b1;
    end
  end

  mem_array #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .i_we    (w_do_write),
    .i_re    (w_do_read),
    .i_addr  (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_arr_rdata)
  );

  // Moore outputs decoded from the state register only.
  assign mem_ready = (r_state == DONE);
  assign mem_err   = (r_state == DONE) & r_err;
  assign busy      = (r_state != IDLE);
  assign rdata     = r_rd_seen ? w_arr_rdata : {DATA_W{1'b0}};

endmodule
